// File: rtl/svo_hdmi_linkctl.sv
// HDMI output-path bring-up sequencer: orders PLL, serializer and encoder resets,
// gated on debounced hot-plug and PLL lock, with bounded retries and a latched fault.
module svo_hdmi_linkctl #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned SETTLE_CYCLES  = 256,
    parameter int unsigned SERDES_CYCLES  = 16,
    parameter int unsigned HPD_DEBOUNCE   = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       locked,
    input  logic       hpd,
    output logic       pll_reset,
    output logic       serdes_reset,
    output logic       enc_resetn,
    output logic       tcard_resetn,
    output logic       active,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CNT_MAX = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                                 max2(SETTLE_CYCLES, SERDES_CYCLES)),
                                           HPD_DEBOUNCE);
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PLL_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_SERDES    = 3'd4,
        S_ACTIVE    = 3'd5,
        S_FAULT     = 3'd7
    } state_t;

    logic [1:0]    locked_q;
    logic [1:0]    hpd_q;
    logic          locked_s;
    logic          hpd_s;
    logic          hpd_db;
    logic [CW-1:0] db_cnt;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] dwell;
    logic [3:0]    retry;
    logic [3:0]    retry_nxt;
    logic [7:0]    llc_nxt;
    logic          attempt_fail;

    assign locked_s = locked_q[1];
    assign hpd_s    = hpd_q[1];
    assign state    = cur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked_q <= '0;
            hpd_q    <= '0;
            hpd_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            locked_q <= {locked_q[0], locked};
            hpd_q    <= {hpd_q[0], hpd};
            // any sample agreeing with the filtered value restarts the count
            if (hpd_s != hpd_db) begin
                if (db_cnt == CW'(HPD_DEBOUNCE - 1)) begin
                    hpd_db <= hpd_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        nxt          = cur;
        retry_nxt    = retry;
        llc_nxt      = lock_loss_cnt;
        attempt_fail = 1'b0;
        if (cur != S_FAULT && (!enable || !hpd_db)) begin
            nxt       = S_OFF;
            retry_nxt = '0;
        end else begin
            case (cur)
                S_OFF:       if (enable && hpd_db) nxt = S_PLL_RST;
                S_PLL_RST:   if (dwell == CW'(PLL_RST_CYCLES - 1)) nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (locked_s)                                nxt = S_SETTLE;
                    else if (dwell == CW'(LOCK_TIMEOUT - 1))     attempt_fail = 1'b1;
                end
                S_SETTLE: begin
                    if (!locked_s)                               attempt_fail = 1'b1;
                    else if (dwell == CW'(SETTLE_CYCLES - 1))    nxt = S_SERDES;
                end
                S_SERDES: begin
                    if (!locked_s) begin
                        attempt_fail = 1'b1;
                    end else if (dwell == CW'(SERDES_CYCLES - 1)) begin
                        nxt       = S_ACTIVE;
                        retry_nxt = '0;
                    end
                end
                S_ACTIVE: begin
                    if (!locked_s) begin
                        nxt = S_PLL_RST;
                        if (lock_loss_cnt != 8'hFF) llc_nxt = lock_loss_cnt + 8'd1;
                    end
                end
                S_FAULT:     if (!enable) nxt = S_OFF;
                default:     nxt = S_OFF;
            endcase
            if (attempt_fail) begin
                retry_nxt = retry + 4'd1;
                nxt       = (retry_nxt == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
            end
        end
    end

    // outputs decode the next state so they switch on the same edge as the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur           <= S_OFF;
            dwell         <= '0;
            retry         <= '0;
            lock_loss_cnt <= '0;
            pll_reset     <= 1'b1;
            serdes_reset  <= 1'b1;
            enc_resetn    <= 1'b0;
            tcard_resetn  <= 1'b0;
            active        <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cur           <= nxt;
            retry         <= retry_nxt;
            lock_loss_cnt <= llc_nxt;
            if (nxt != cur)       dwell <= '0;
            else if (dwell != '1) dwell <= dwell + 1'b1;
            pll_reset     <= (nxt == S_OFF) || (nxt == S_PLL_RST) || (nxt == S_FAULT);
            serdes_reset  <= !((nxt == S_SERDES) || (nxt == S_ACTIVE));
            enc_resetn    <= (nxt == S_ACTIVE);
            tcard_resetn  <= (nxt == S_ACTIVE);
            active        <= (nxt == S_ACTIVE);
            fault         <= (nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_svo_hdmi_linkctl.sv
// Bench for svo_hdmi_linkctl: a cycle model pushes expected outputs per edge into a
// queue that is compared on the falling edge, plus directed timing checks.
module tb_svo_hdmi_linkctl;

    localparam int unsigned PLL  = 4;
    localparam int unsigned LT   = 20;
    localparam int unsigned SETC = 8;
    localparam int unsigned SERC = 4;
    localparam int unsigned DB   = 6;
    localparam int unsigned MR   = 2;

    logic       clk = 1'b0;
    logic       resetn, enable, locked, hpd;
    logic       pll_reset, serdes_reset, enc_resetn, tcard_resetn, active, fault;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;
    logic [16:0] obs;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    svo_hdmi_linkctl #(
        .PLL_RST_CYCLES(PLL),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SETC),
        .SERDES_CYCLES (SERC),
        .HPD_DEBOUNCE  (DB),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .locked       (locked),
        .hpd          (hpd),
        .pll_reset    (pll_reset),
        .serdes_reset (serdes_reset),
        .enc_resetn   (enc_resetn),
        .tcard_resetn (tcard_resetn),
        .active       (active),
        .fault        (fault),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pll_reset, serdes_reset, enc_resetn, tcard_resetn, active, fault, state, lock_loss_cnt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] pack(input int st, input int llc);
        logic p, s, e;
        p = (st == 0) || (st == 1) || (st == 7);
        s = !((st == 4) || (st == 5));
        e = (st == 5);
        return {p, s, e, e, e, (st == 7), 3'(st), 8'(llc)};
    endfunction

    // reference model: one update per rising edge, expected outputs queued
    int m_st, m_cnt, m_retry, m_llc, m_dbc;
    bit m_l1, m_ls, m_h1, m_hs, m_hdb;
    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_st = 0; m_cnt = 0; m_retry = 0; m_llc = 0; m_dbc = 0;
                m_l1 = 0; m_ls = 0; m_h1 = 0; m_hs = 0; m_hdb = 0;
                exp_q.delete();
                exp_q.push_back(pack(0, 0));
            end else begin
                int n_st, n_retry, n_llc, n_dbc;
                bit fail_att, n_hdb;
                n_st = m_st; n_retry = m_retry; n_llc = m_llc; fail_att = 0;
                if (m_st != 7 && (!enable || !m_hdb)) begin
                    n_st = 0; n_retry = 0;
                end else begin
                    case (m_st)
                        0: if (enable && m_hdb) n_st = 1;
                        1: if (m_cnt >= PLL - 1) n_st = 2;
                        2: if (m_ls) n_st = 3; else if (m_cnt >= LT - 1) fail_att = 1;
                        3: if (!m_ls) fail_att = 1; else if (m_cnt >= SETC - 1) n_st = 4;
                        4: if (!m_ls) fail_att = 1;
                           else if (m_cnt >= SERC - 1) begin n_st = 5; n_retry = 0; end
                        5: if (!m_ls) begin n_st = 1; if (m_llc < 255) n_llc = m_llc + 1; end
                        7: if (!enable) n_st = 0;
                        default: n_st = 0;
                    endcase
                    if (fail_att) begin
                        n_retry = m_retry + 1;
                        n_st = (n_retry == MR) ? 7 : 1;
                    end
                end
                n_hdb = m_hdb; n_dbc = 0;
                if (m_hs != m_hdb) begin
                    if (m_dbc + 1 >= DB) n_hdb = m_hs;
                    else n_dbc = m_dbc + 1;
                end
                m_cnt = (n_st != m_st) ? 0 : m_cnt + 1;
                m_st = n_st; m_retry = n_retry; m_llc = n_llc;
                m_hdb = n_hdb; m_dbc = n_dbc;
                m_ls = m_l1; m_l1 = locked;
                m_hs = m_h1; m_h1 = hpd;
                exp_q.push_back(pack(m_st, m_llc));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("outputs", obs, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, st);
    endtask

    task automatic count_state(input logic [2:0] st, output int n);
        n = 0;
        while (state === st && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0; enable = 1'b1; hpd = 1'b0; locked = 1'b0;
        cyc(2);
        check("reset_state", obs, pack(0, 0));
        cyc(1);
        resetn = 1'b1;

        // hpd glitches shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            hpd = 1'b1; cyc(3);
            hpd = 1'b0; cyc(3);
        end
        cyc(4);
        check("glitch_state", state, 3'd0);
        check("glitch_resets", {pll_reset, serdes_reset, enc_resetn, tcard_resetn}, 4'b1100);

        // nominal bring-up
        hpd = 1'b1;
        wait_state(3'd1, 40, "reach_pll_rst");
        count_state(3'd1, n);
        check("pll_rst_len", n, PLL);
        cyc(4);
        locked = 1'b1;
        wait_state(3'd3, 40, "reach_settle");
        count_state(3'd3, n);
        check("settle_len", n, SETC);
        count_state(3'd4, n);
        check("serdes_len", n, SERC);
        check("nominal_state", state, 3'd5);
        check("nominal_active", active, 1'b1);

        // single-cycle lock loss while active
        locked = 1'b0;
        cyc(1); locked = 1'b1;
        cyc(1);
        check("loss_active_p2", active, 1'b1);
        cyc(1);
        check("loss_resets", {pll_reset, serdes_reset, enc_resetn}, 3'b110);
        check("loss_cnt1", lock_loss_cnt, 8'd1);
        wait_state(3'd5, 60, "reactivate");
        for (int i = 0; i < 299; i++) begin
            locked = 1'b0;
            cyc(1); locked = 1'b1;
            cyc(2);
            wait_state(3'd5, 60, "reactivate_loop");
        end
        check("loss_cnt_sat", lock_loss_cnt, 8'd255);

        // lock timeout, twice, then fault
        locked = 1'b0;
        wait_state(3'd7, 200, "timeout_fault");
        check("fault_flag", fault, 1'b1);
        hpd = 1'b0;
        cyc(20);
        check("fault_ignores_hpd", state, 3'd7);
        enable = 1'b0;
        cyc(1);
        check("fault_exit_state", state, 3'd0);
        check("fault_exit_flag", fault, 1'b0);

        // lock lost during settle, twice
        enable = 1'b1; hpd = 1'b1; locked = 1'b1;
        wait_state(3'd3, 60, "s5_settle1");
        cyc(4);
        locked = 1'b0;
        wait_state(3'd1, 10, "s5_retry");
        locked = 1'b1;
        wait_state(3'd3, 40, "s5_settle2");
        cyc(4);
        locked = 1'b0;
        wait_state(3'd7, 10, "s5_fault");
        enable = 1'b0;
        cyc(2);
        check("s5_off", state, 3'd0);

        // asynchronous reset mid-serdes
        enable = 1'b1; locked = 1'b1;
        wait_state(3'd4, 80, "reach_serdes");
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("async_reset", obs, pack(0, 0));
        #4 resetn = 1'b1;
        wait_state(3'd5, 80, "after_reset_active");
        check("after_reset_llc", lock_loss_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
